// File: rtl/ad7476a_sample_averager_if.sv
// Converter-side request/sample handshake plus the averaged valid/ready result stream.
// master: the averager; slave: converter driver and result consumer.
interface ad7476a_sample_averager_if;
  logic        adc_request_o;
  logic [11:0] adc_data_i;
  logic        adc_valid_i;
  logic [11:0] sample_o;
  logic        sample_valid_o;
  logic        sample_ready_i;

  modport master (
    output adc_request_o,
    input  adc_data_i,
    input  adc_valid_i,
    output sample_o,
    output sample_valid_o,
    input  sample_ready_i
  );

  modport slave (
    input  adc_request_o,
    output adc_data_i,
    output adc_valid_i,
    input  sample_o,
    input  sample_valid_o,
    output sample_ready_i
  );
endinterface

// File: rtl/ad7476a_sample_averager.sv
// Paces AD7476A conversions from a fixed-rate tick, averages 2^AVG_LOG2 samples and
// emits the result on a single-entry valid/ready register. Define ADC_AVG_ROUND_EN to round half up.
module ad7476a_sample_averager #(
  parameter int unsigned CLK_FREQ_HZ    = 100000000,
  parameter int unsigned SAMPLE_RATE_HZ = 1000000,
  parameter int unsigned AVG_LOG2       = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              enable_i,
  ad7476a_sample_averager_if.master         bus,
  output logic                              tick_missed_o,
  output logic                              overrun_o,
  input  logic                              clear_status_i
);

  localparam int unsigned TICK_PERIOD = CLK_FREQ_HZ / SAMPLE_RATE_HZ;
  localparam int unsigned CW = (TICK_PERIOD > 2) ? $clog2(TICK_PERIOD) : 1;
  localparam int unsigned AW = 12 + AVG_LOG2;
  localparam int unsigned NW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] TICK_RELOAD = CW'(TICK_PERIOD - 1);
  localparam logic [NW-1:0] N_SAMPLES   = NW'(32'd1 << AVG_LOG2);
`ifdef ADC_AVG_ROUND_EN
  localparam int unsigned ROUND_K = (32'd1 << AVG_LOG2) >> 1;
`else
  localparam int unsigned ROUND_K = 0;
`endif
  localparam logic [AW-1:0] ROUND_AW = AW'(ROUND_K);

  if (TICK_PERIOD < 2) begin : g_bad_rate
    $error("CLK_FREQ_HZ/SAMPLE_RATE_HZ must be at least 2");
  end
  if (AVG_LOG2 > 8) begin : g_bad_avg
    $error("AVG_LOG2 must be in 0..8");
  end

  typedef enum logic [1:0] {IDLE, PENDING, ACCUM} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [NW-1:0]   count_q, count_d;
  logic [11:0]     smp_q, smp_d;
  logic            abort_q, abort_d;
  logic [11:0]     out_q, out_d;
  logic            out_vld_q, out_vld_d;
  logic            miss_q, miss_d;
  logic            ovr_q, ovr_d;

  logic            tick;
  logic            req;
  logic            load;
  logic            set_miss;
  logic            set_ovr;
  logic [AW-1:0]   sum;
  logic [AW-1:0]   sum_rnd;
  logic [11:0]     result;
  logic [NW-1:0]   count_inc;

  // Counter parks at the reload value while disabled so the first tick is a full period out.
  always_comb begin
    tick = enable_i && (tick_cnt_q == '0);
    if (!enable_i || tick) begin
      tick_cnt_d = TICK_RELOAD;
    end else begin
      tick_cnt_d = tick_cnt_q - CW'(1);
    end
  end

  // Width 12+AVG_LOG2 holds N full-scale samples plus N/2, so the sum never wraps.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    smp_d     = smp_q;
    abort_d   = abort_q;
    req       = 1'b0;
    set_miss  = 1'b0;
    load      = 1'b0;
    sum       = acc_q + AW'(smp_q);
    sum_rnd   = sum + ROUND_AW;
    result    = 12'(sum_rnd >> AVG_LOG2);
    count_inc = count_q + NW'(1);
    unique case (state_q)
      IDLE: begin
        if (tick) state_d = PENDING;
      end
      PENDING: begin
        set_miss = tick;
        req      = !bus.adc_valid_i;
        if (!enable_i) abort_d = 1'b1;
        if (bus.adc_valid_i) begin
          abort_d = 1'b0;
          if (abort_q || !enable_i) begin
            acc_d   = '0;
            count_d = '0;
            state_d = IDLE;
          end else begin
            smp_d   = bus.adc_data_i;
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        set_miss = tick;
        state_d  = IDLE;
        if (count_inc == N_SAMPLES) begin
          acc_d   = '0;
          count_d = '0;
          load    = 1'b1;
        end else begin
          acc_d   = sum;
          count_d = count_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_d     = out_q;
    out_vld_d = out_vld_q;
    set_ovr   = 1'b0;
    if (load) begin
      if (!out_vld_q || bus.sample_ready_i) begin
        out_d     = result;
        out_vld_d = 1'b1;
      end else begin
        set_ovr = 1'b1;
      end
    end else if (out_vld_q && bus.sample_ready_i) begin
      out_vld_d = 1'b0;
    end
    miss_d = set_miss ? 1'b1 : (clear_status_i ? 1'b0 : miss_q);
    ovr_d  = set_ovr  ? 1'b1 : (clear_status_i ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      tick_cnt_q <= TICK_RELOAD;
      acc_q      <= '0;
      count_q    <= '0;
      smp_q      <= '0;
      abort_q    <= 1'b0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      miss_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      smp_q      <= smp_d;
      abort_q    <= abort_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      miss_q     <= miss_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.adc_request_o  = req;
  assign bus.sample_o       = out_q;
  assign bus.sample_valid_o = out_vld_q;
  assign tick_missed_o      = miss_q;
  assign overrun_o          = ovr_q;

endmodule

// File: tb/tb_ad7476a_sample_averager.sv
// Bench for ad7476a_sample_averager: converter model, per-cycle reference model, directed scenarios.
module tb_ad7476a_sample_averager;
  localparam int TP = 100;
  localparam int N  = 4;
`ifdef ADC_AVG_ROUND_EN
  localparam int RND   = N / 2;
  localparam int EXP_A = 102;
`else
  localparam int RND   = 0;
  localparam int EXP_A = 101;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_ni, enable, clear_status, tick_missed, overrun;
  logic en0, clr0, miss0, ovr0;

  ad7476a_sample_averager_if bus ();
  ad7476a_sample_averager_if bus0 ();

  ad7476a_sample_averager #(
    .CLK_FREQ_HZ(100000000), .SAMPLE_RATE_HZ(1000000), .AVG_LOG2(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable), .bus(bus),
    .tick_missed_o(tick_missed), .overrun_o(overrun), .clear_status_i(clear_status)
  );

  ad7476a_sample_averager #(
    .CLK_FREQ_HZ(100000000), .SAMPLE_RATE_HZ(10000000), .AVG_LOG2(0)
  ) dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(en0), .bus(bus0),
    .tick_missed_o(miss0), .overrun_o(ovr0), .clear_status_i(clr0)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Converter model: starts on a sampled request, strobes conv_delay edges later.
  int conv_q[$];
  int conv_delay = 19;
  int n_strobe = 0;
  initial begin
    logic r;
    int   cnt;
    bit   busy;
    busy = 0;
    cnt  = 0;
    bus.adc_valid_i = 1'b0;
    bus.adc_data_i  = '0;
    forever begin
      @(negedge clk);
      r = bus.adc_request_o;
      @(posedge clk);
      #1;
      bus.adc_valid_i = 1'b0;
      if (!rst_ni) begin
        busy = 0;
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          busy = 0;
          bus.adc_data_i  = (conv_q.size() > 0) ? 12'(conv_q.pop_front()) : 12'd0;
          bus.adc_valid_i = 1'b1;
          n_strobe++;
        end
      end else if (r) begin
        busy = 1;
        cnt  = conv_delay;
      end
    end
  end

  // Reference model: ticks from count of enabled cycles, sample history averaged by division.
  bit m_pend, m_acc, m_abort, m_vld, m_miss, m_ovr, req_prev;
  int m_dat, m_smp, en_run, cyc;
  int hist[$];
  int got[$];
  int rises[$];
  initial begin
    bit tick, set_miss, set_ovr, load, nxt_acc, nxt_pend;
    int sum, res;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_ni) begin
        m_pend = 0; m_acc = 0; m_abort = 0; m_vld = 0; m_miss = 0; m_ovr = 0;
        m_dat = 0; m_smp = 0; en_run = 0; req_prev = 0;
        hist.delete();
      end else begin
        chk("request", bus.adc_request_o, m_pend && !bus.adc_valid_i);
        chk("sample_valid", bus.sample_valid_o, m_vld);
        if (m_vld) chk("sample_data", bus.sample_o, m_dat);
        chk("tick_missed", tick_missed, m_miss);
        chk("overrun", overrun, m_ovr);
        if (bus.sample_valid_o && bus.sample_ready_i) got.push_back(int'(bus.sample_o));
        if (bus.adc_request_o && !req_prev) rises.push_back(cyc);
        req_prev = bus.adc_request_o;

        tick     = enable && ((en_run + 1) % TP == 0);
        en_run   = enable ? en_run + 1 : 0;
        set_miss = tick && (m_pend || m_acc);
        set_ovr  = 0;
        load     = 0;
        res      = 0;
        if (m_acc) begin
          hist.push_back(m_smp);
          if (hist.size() == N) begin
            sum = 0;
            foreach (hist[i]) sum += hist[i];
            res  = (sum + RND) / N;
            load = 1;
            hist.delete();
          end
        end
        nxt_acc = 0;
        if (m_pend && bus.adc_valid_i) begin
          if (m_abort || !enable) hist.delete();
          else begin
            nxt_acc = 1;
            m_smp   = int'(bus.adc_data_i);
          end
        end
        if (load) begin
          if (!m_vld || bus.sample_ready_i) begin
            m_vld = 1;
            m_dat = res;
          end else set_ovr = 1;
        end else if (m_vld && bus.sample_ready_i) m_vld = 0;
        m_miss   = set_miss ? 1'b1 : (clear_status ? 1'b0 : m_miss);
        m_ovr    = set_ovr ? 1'b1 : (clear_status ? 1'b0 : m_ovr);
        nxt_pend = m_pend ? !bus.adc_valid_i : (!m_acc && tick);
        m_abort  = m_pend && !bus.adc_valid_i && (m_abort || !enable);
        m_pend   = nxt_pend;
        m_acc    = nxt_acc;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_strobes(input int n, input int limit);
    int target, k;
    target = n_strobe + n;
    k = 0;
    while (n_strobe < target && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("strobe_wait", n_strobe >= target, 1);
  endtask

  task automatic req_latency(input string name, input int exp);
    int n;
    n = 0;
    while (!bus.adc_request_o && n < 300) begin
      step(1);
      n++;
    end
    chk(name, n, exp);
  endtask

  task automatic avg0_sample(input logic [11:0] d, input string name);
    int n;
    n = 0;
    while (!bus0.adc_request_o && n < 50) begin
      step(1);
      n++;
    end
    chk({name, "_req"}, bus0.adc_request_o, 1);
    step(2);
    bus0.adc_data_i  = d;
    bus0.adc_valid_i = 1'b1;
    step(1);
    bus0.adc_valid_i = 1'b0;
    n = 1;
    while (!bus0.sample_valid_o && n < 10) begin
      step(1);
      n++;
    end
    chk({name, "_latency"}, n, 2);
    chk({name, "_data"}, bus0.sample_o, d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int gs, rb;
    rst_ni = 1'b0; enable = 1'b0; clear_status = 1'b0; bus.sample_ready_i = 1'b1;
    en0 = 1'b0; clr0 = 1'b0; bus0.sample_ready_i = 1'b1;
    bus0.adc_valid_i = 1'b0; bus0.adc_data_i = '0;
    #1;
    chk("rst_request", bus.adc_request_o, 0);
    chk("rst_valid", bus.sample_valid_o, 0);
    chk("rst_sample", bus.sample_o, 0);
    chk("rst_missed", tick_missed, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_valid0", bus0.sample_valid_o, 0);
    step(3);
    rst_ni = 1'b1;
    step(1);

    // Four samples at default averaging.
    conv_q = {100, 101, 102, 103};
    enable = 1'b1;
    req_latency("first_req_latency", 100);
    gs = got.size();
    wait_strobes(4, 600);
    step(3);
    chk("avg_a_count", got.size() - gs, 1);
    chk("avg_a_value", got[$], EXP_A);
    chk("req_spacing_01", rises[1] - rises[0], 100);
    chk("req_spacing_23", rises[3] - rises[2], 100);

    // Slow converter: tick lands while pending.
    conv_delay = 149;
    conv_q.push_back(10);
    rb = rises.size();
    wait_strobes(1, 400);
    chk("slow_missed", tick_missed, 1);
    chk("slow_req_low_at_strobe", bus.adc_request_o, 0);
    chk("slow_single_request", rises.size() - rb, 1);
    step(1);
    conv_delay = 19;
    conv_q = {20, 30, 40};
    clear_status = 1'b1;
    step(1);
    clear_status = 1'b0;
    chk("missed_cleared", tick_missed, 0);
    wait_strobes(3, 500);
    step(3);
    chk("avg_b_value", got[$], 25);

    // Consumer stalled across two averages.
    bus.sample_ready_i = 1'b0;
    conv_q = {40, 40, 40, 40, 80, 80, 80, 80};
    wait_strobes(8, 1100);
    step(3);
    chk("stall_valid", bus.sample_valid_o, 1);
    chk("stall_sample", bus.sample_o, 40);
    chk("stall_overrun", overrun, 1);
    bus.sample_ready_i = 1'b1;
    step(1);
    chk("stall_consumed", got[$], 40);
    chk("stall_valid_dropped", bus.sample_valid_o, 0);

    // Disable while pending after two accumulated samples.
    gs = got.size();
    conv_q = {500, 500, 999};
    wait_strobes(2, 400);
    req_latency("third_req_seen", 100 - 20);
    enable = 1'b0;
    step(5);
    chk("abort_req_held", bus.adc_request_o, 1);
    wait_strobes(1, 100);
    step(10);
    chk("abort_no_output", got.size() - gs, 0);
    chk("abort_valid_low", bus.sample_valid_o, 0);
    enable = 1'b1;
    conv_q = {200, 200, 200, 200};
    wait_strobes(4, 700);
    step(3);
    chk("reenable_count", got.size() - gs, 1);
    chk("reenable_value", got[$], 200);

    // Asynchronous reset while pending with flags set and a result held.
    bus.sample_ready_i = 1'b0;
    conv_q = {7, 7, 7, 7};
    wait_strobes(4, 600);
    step(3);
    chk("held_valid", bus.sample_valid_o, 1);
    chk("held_sample", bus.sample_o, 7);
    conv_delay = 149;
    begin
      int n;
      n = 0;
      while (!tick_missed && n < 400) begin
        step(1);
        n++;
      end
    end
    chk("pre_rst_missed", tick_missed, 1);
    chk("pre_rst_request", bus.adc_request_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("async_request", bus.adc_request_o, 0);
    chk("async_valid", bus.sample_valid_o, 0);
    chk("async_missed", tick_missed, 0);
    chk("async_overrun", overrun, 0);
    step(2);
    rst_ni = 1'b1;
    conv_delay = 19;
    bus.sample_ready_i = 1'b1;
    req_latency("post_rst_req_latency", 100);

    // Pass-through instance.
    en0 = 1'b1;
    avg0_sample(12'hFFF, "avg0_fff");
    avg0_sample(12'h000, "avg0_000");
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ad7476a_sample_averager.md
Name: ad7476a_sample_averager

Overview:
Downstream companion to the AD7476A SPI interface. It paces conversions by driving the interface's request input from a fixed-rate tick, and consumes each returned 12-bit sample. It averages 2^AVG_LOG2 samples and presents the decimated result on a valid/ready stream to the DSP/logging fabric. Missed ticks and output overruns are flagged as sticky status.

Parameters:
- CLK_FREQ_HZ, 100000000, system clock frequency.
- SAMPLE_RATE_HZ, 1000000, conversion request rate. TICK_PERIOD = CLK_FREQ_HZ/SAMPLE_RATE_HZ must be >= 2; otherwise elaboration fails.
- AVG_LOG2, 2, log2 of the samples per output word (0..8). At 0 every sample passes through unaveraged.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- enable_i  in  1  run/stop conversion pacing.
- adc_request_o  out  1  to the converter's request_i.
- adc_data_i  in  12  from the converter's data_o.
- adc_valid_i  in  1  from the converter's data_valid_o; single-cycle strobe.
- sample_o  out  12  averaged result.
- sample_valid_o  out  1  result valid.
- sample_ready_i  in  1  consumer accepts the result.
- tick_missed_o  out  1  sticky flag: a tick arrived while a conversion was outstanding.
- overrun_o  out  1  sticky flag: a result was dropped because the output register was full.
- clear_status_i  in  1  clears both sticky flags.

Behaviour:
- Reset (async assert, sync release): state IDLE, tick counter = TICK_PERIOD-1, accumulator 0, sample count 0. All outputs are 0.
- Tick counter:
  - Decrements while enable_i=1; tick fires when it reaches 0, and the counter reloads TICK_PERIOD-1 on the same cycle.
  - While enable_i=0 it holds at TICK_PERIOD-1, so the first tick comes TICK_PERIOD cycles after enable_i rises.
- FSM states: IDLE, PENDING, ACCUM.
  - IDLE -> PENDING on tick.
  - PENDING: adc_request_o = !adc_valid_i (combinational). The request therefore drops in the strobe cycle and never retriggers the converter from its strobe state. PENDING -> ACCUM on adc_valid_i, with adc_data_i registered on that cycle.
  - ACCUM: one cycle. Adds the registered sample to the accumulator and increments the count, then -> IDLE.
- A tick in PENDING or ACCUM sets tick_missed_o and is otherwise ignored; no request is queued.
- Accumulator width is 12+AVG_LOG2 bits, so it cannot overflow.
- When the count reaches 2^AVG_LOG2 in ACCUM:
  - result = (acc + new sample) >> AVG_LOG2, truncated.
  - Accumulator and count clear.
  - The result loads the output register on the next edge. Latency is 2 cycles from the final adc_valid_i to sample_valid_o.
- Output register is a single entry.
  - sample_valid_o stays high until a cycle with sample_ready_i=1, and sample_o is stable meanwhile.
  - Load and accept in the same cycle: the new result replaces the old one and valid stays high.
  - Load while valid and !sample_ready_i: the new result is dropped, overrun_o is set, and the old result is kept.
- clear_status_i clears both flags. If a set event occurs in the same cycle, the set wins.
- enable_i falling mid-conversion: the PENDING conversion completes normally (request held until the strobe). That sample is discarded, and the accumulator and count clear. The FSM returns to IDLE and the output register is untouched.
- adc_valid_i outside PENDING is ignored.

Optional Feature:
ADC_AVG_ROUND_EN.
- Defined: result = (sum + 2^(AVG_LOG2-1)) >> AVG_LOG2, i.e. round half up. No overflow is possible because max (4095*N + N/2) >> AVG_LOG2 = 4095. With AVG_LOG2=0 the rounding constant is 0.
- Undefined: truncation as above.

Test Plan:
- Reset mid-PENDING with rst_ni pulsed low: adc_request_o, sample_valid_o and both flags drop to 0 immediately (asynchronously). The first request comes 100 cycles after enable_i with defaults.
- Defaults, ready=1, converter model returns 100,101,102,103: exactly one sample_valid_o with sample_o=101. With ADC_AVG_ROUND_EN the value is 102. Requests are spaced 100 cycles apart.
- AVG_LOG2=0, samples 0xFFF then 0x000: outputs 0xFFF then 0x000, each 2 cycles after its strobe.
- Converter strobe delayed to 150 cycles after the request: tick_missed_o=1, no extra request pulse, and adc_request_o low in the strobe cycle. clear_status_i then clears the flag.
- sample_ready_i held low across two completed averages: first result is held, overrun_o=1, and sample_o still equals the first result. Raising ready consumes it.
- enable_i dropped while PENDING after 2 accumulated samples: request is held until the strobe, the accumulator clears, and no output is produced. Re-enabling and feeding 4×200 yields 200.
